// File: rtl/output_descriptor_arbiter.sv
// output_descriptor_arbiter
//   Per-outport arbiter that merges the host and network descriptor sources
//   into one descriptor stream for the outport's queue manager.
//   Priority order: single requester, starvation guard, time-sensitive type,
//   then round-robin.
//
// Optional feature (macro DESC_ARB_STAT_EN):
//   When defined, ov_host_grant_cnt / ov_network_grant_cnt count acks issued to
//   each source (16-bit, wrapping). When undefined, both ports are tied to 0.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   iv_*_host, i_descriptor_wr_host       host descriptor + request
//   o_descriptor_ack_host                 one-cycle ack to host
//   iv_*_network, i_descriptor_wr_network network descriptor + request
//   o_descriptor_ack_network              one-cycle ack to network
//   ov_tsntag/ov_pkt_type/ov_bufid        granted descriptor
//   o_descriptor_wr, i_descriptor_ack     handshake to queue manager
//   ov_host_grant_cnt, ov_network_grant_cnt  grant statistics
module output_descriptor_arbiter #(
  parameter logic [2:0]  TS_TYPE_MAX  = 3'd2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [47:0] iv_tsntag_host,
  input  logic [2:0]  iv_pkt_type_host,
  input  logic [8:0]  iv_bufid_host,
  input  logic        i_descriptor_wr_host,
  output logic        o_descriptor_ack_host,
  input  logic [47:0] iv_tsntag_network,
  input  logic [2:0]  iv_pkt_type_network,
  input  logic [8:0]  iv_bufid_network,
  input  logic        i_descriptor_wr_network,
  output logic        o_descriptor_ack_network,
  output logic [47:0] ov_tsntag,
  output logic [2:0]  ov_pkt_type,
  output logic [8:0]  ov_bufid,
  output logic        o_descriptor_wr,
  input  logic        i_descriptor_ack,
  output logic [15:0] ov_host_grant_cnt,
  output logic [15:0] ov_network_grant_cnt
);

  localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);
  localparam logic       StarveEn    = (StarveLimit != 8'd0);

  typedef enum logic [1:0] {StIdle, StWaitAck, StRelease} state_e;

  state_e     state_q;
  logic       winner_host_q;  // source granted in the current transaction
  logic       rr_last_net_q;  // 1: network won the last grant
  logic [7:0] host_starve_q;
  logic [7:0] net_starve_q;

  logic host_ts, net_ts;
  logic host_starved, net_starved;
  logic any_req;
  logic pick_host;

  assign host_ts      = (iv_pkt_type_host <= TS_TYPE_MAX);
  assign net_ts       = (iv_pkt_type_network <= TS_TYPE_MAX);
  assign host_starved = StarveEn && (host_starve_q >= StarveLimit);
  assign net_starved  = StarveEn && (net_starve_q >= StarveLimit);
  assign any_req      = i_descriptor_wr_host | i_descriptor_wr_network;

  always_comb begin
    pick_host = 1'b0;
    if (i_descriptor_wr_host && !i_descriptor_wr_network) begin
      pick_host = 1'b1;
    end else if (!i_descriptor_wr_host && i_descriptor_wr_network) begin
      pick_host = 1'b0;
    end else if (host_starved != net_starved) begin
      pick_host = host_starved;
    end else if (host_ts != net_ts) begin
      pick_host = host_ts;
    end else begin
      pick_host = rr_last_net_q;
    end
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q                  <= StIdle;
      winner_host_q            <= 1'b0;
      rr_last_net_q            <= 1'b1;
      host_starve_q            <= 8'd0;
      net_starve_q             <= 8'd0;
      ov_tsntag                <= 48'd0;
      ov_pkt_type              <= 3'd0;
      ov_bufid                 <= 9'd0;
      o_descriptor_wr          <= 1'b0;
      o_descriptor_ack_host    <= 1'b0;
      o_descriptor_ack_network <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            winner_host_q   <= pick_host;
            o_descriptor_wr <= 1'b1;
            state_q         <= StWaitAck;
            if (pick_host) begin
              ov_tsntag     <= iv_tsntag_host;
              ov_pkt_type   <= iv_pkt_type_host;
              ov_bufid      <= iv_bufid_host;
              host_starve_q <= 8'd0;
              if (i_descriptor_wr_network) net_starve_q <= sat_inc(net_starve_q);
            end else begin
              ov_tsntag    <= iv_tsntag_network;
              ov_pkt_type  <= iv_pkt_type_network;
              ov_bufid     <= iv_bufid_network;
              net_starve_q <= 8'd0;
              if (i_descriptor_wr_host) host_starve_q <= sat_inc(host_starve_q);
            end
          end
        end
        StWaitAck: begin
          if (i_descriptor_ack) begin
            o_descriptor_wr          <= 1'b0;
            o_descriptor_ack_host    <= winner_host_q;
            o_descriptor_ack_network <= !winner_host_q;
            rr_last_net_q            <= !winner_host_q;
            state_q                  <= StRelease;
          end
        end
        StRelease: begin
          // Requests are ignored here; the source drops wr at this cycle's end.
          o_descriptor_ack_host    <= 1'b0;
          o_descriptor_ack_network <= 1'b0;
          state_q                  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DESC_ARB_STAT_EN
  logic [15:0] host_cnt_q, net_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      host_cnt_q <= 16'd0;
      net_cnt_q  <= 16'd0;
    end else if (state_q == StWaitAck && i_descriptor_ack) begin
      if (winner_host_q) host_cnt_q <= host_cnt_q + 16'd1;
      else               net_cnt_q  <= net_cnt_q + 16'd1;
    end
  end

  assign ov_host_grant_cnt    = host_cnt_q;
  assign ov_network_grant_cnt = net_cnt_q;
`else
  assign ov_host_grant_cnt    = 16'd0;
  assign ov_network_grant_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_output_descriptor_arbiter.sv
// Directed bench for output_descriptor_arbiter (STARVE_LIMIT = 8).
module tb_output_descriptor_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] tag_h = '0, tag_n = '0;
  logic [2:0]  type_h = '0, type_n = '0;
  logic [8:0]  buf_h = '0, buf_n = '0;
  logic        wr_h = 1'b0, wr_n = 1'b0;
  logic        ack_h, ack_n;
  logic [47:0] tag_o;
  logic [2:0]  type_o;
  logic [8:0]  buf_o;
  logic        wr_o;
  logic        qm_ack = 1'b0;
  logic [15:0] cnt_h, cnt_n;

  int n_vec = 0;
  int n_err = 0;

`ifdef DESC_ARB_STAT_EN
  localparam logic [15:0] StatOne = 16'd1;
`else
  localparam logic [15:0] StatOne = 16'd0;
`endif

  output_descriptor_arbiter #(
    .TS_TYPE_MAX (3'd2),
    .STARVE_LIMIT(8)
  ) dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .iv_tsntag_host          (tag_h),
    .iv_pkt_type_host        (type_h),
    .iv_bufid_host           (buf_h),
    .i_descriptor_wr_host    (wr_h),
    .o_descriptor_ack_host   (ack_h),
    .iv_tsntag_network       (tag_n),
    .iv_pkt_type_network     (type_n),
    .iv_bufid_network        (buf_n),
    .i_descriptor_wr_network (wr_n),
    .o_descriptor_ack_network(ack_n),
    .ov_tsntag               (tag_o),
    .ov_pkt_type             (type_o),
    .ov_bufid                (buf_o),
    .o_descriptor_wr         (wr_o),
    .i_descriptor_ack        (qm_ack),
    .ov_host_grant_cnt       (cnt_h),
    .ov_network_grant_cnt    (cnt_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset deasserted at a falling edge, so the next rising edge is IDLE.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full transaction with qm_ack held high: wr, ack pulse, back to IDLE.
  task automatic observe(input logic exp_host, input logic [8:0] exp_buf, input logic drop,
                         input string tag);
    tick();
    check({tag, " wr"}, 64'(wr_o), 64'd1);
    check({tag, " bufid"}, 64'(buf_o), 64'(exp_buf));
    tick();
    check({tag, " ack_host"}, 64'(ack_h), 64'(exp_host));
    check({tag, " ack_net"}, 64'(ack_n), 64'(!exp_host));
    check({tag, " wr_clear"}, 64'(wr_o), 64'd0);
    if (drop) begin
      if (exp_host) wr_h = 1'b0;
      else          wr_n = 1'b0;
    end
    tick();
    check({tag, " acks_low"}, 64'({ack_h, ack_n}), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst wr", 64'(wr_o), 64'd0);
    check("rst acks", 64'({ack_h, ack_n}), 64'd0);
    check("rst desc", 64'({tag_o, type_o, buf_o}), 64'd0);
    check("rst cnts", 64'({cnt_h, cnt_n}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Host-only request, queue manager acks two cycles after wr rises
    tag_h = 48'h1; type_h = 3'd3; buf_h = 9'h05; wr_h = 1'b1;
    tick();
    check("s1 wr", 64'(wr_o), 64'd1);
    check("s1 bufid", 64'(buf_o), 64'h05);
    check("s1 tag", 64'(tag_o), 64'h1);
    check("s1 type", 64'(type_o), 64'd3);
    tick();
    check("s1 wr_hold", 64'(wr_o), 64'd1);
    check("s1 no_early_ack", 64'(ack_h), 64'd0);
    qm_ack = 1'b1;
    tick();
    check("s1 ack_host", 64'(ack_h), 64'd1);
    check("s1 ack_net", 64'(ack_n), 64'd0);
    check("s1 wr_clear", 64'(wr_o), 64'd0);
    qm_ack = 1'b0; wr_h = 1'b0;
    tick();
    check("s1 ack_host_1cyc", 64'(ack_h), 64'd0);
    check("s1 ack_net_low", 64'(ack_n), 64'd0);
    tick();
    check("s1 idle_wr", 64'(wr_o), 64'd0);

    // Simultaneous: host non-TS, network TS -> network first
    qm_ack = 1'b1;
    tag_h = 48'h10; type_h = 3'd5; buf_h = 9'h10; wr_h = 1'b1;
    tag_n = 48'h20; type_n = 3'd1; buf_n = 9'h20; wr_n = 1'b1;
    observe(1'b0, 9'h20, 1'b1, "s2 net_first");
    observe(1'b1, 9'h10, 1'b1, "s2 host_second");

    // Both non-TS, continuous: round-robin starting with host
    type_h = 3'd5; buf_h = 9'h11; wr_h = 1'b1;
    type_n = 3'd6; buf_n = 9'h21; wr_n = 1'b1;
    do_reset();
    observe(1'b1, 9'h11, 1'b0, "s3 rr0");
    observe(1'b0, 9'h21, 1'b0, "s3 rr1");
    observe(1'b1, 9'h11, 1'b0, "s3 rr2");
    observe(1'b0, 9'h21, 1'b0, "s3 rr3");

    // Host always TS, network non-TS: 8 host grants then one forced network grant
    type_h = 3'd0; buf_h = 9'h30;
    type_n = 3'd7; buf_n = 9'h40;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 8; i++) observe(1'b1, 9'h30, 1'b0, "s4 host_ts");
      observe(1'b0, 9'h40, 1'b0, "s4 forced_net");
    end
    wr_h = 1'b0; wr_n = 1'b0;

    // Reset pulsed mid-transaction
    do_reset();
    qm_ack = 1'b0;
    buf_h = 9'h55; type_h = 3'd4; wr_h = 1'b1;
    tick();
    check("s5 wr_before_rst", 64'(wr_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5 async_wr", 64'(wr_o), 64'd0);
    check("s5 async_acks", 64'({ack_h, ack_n}), 64'd0);
    check("s5 async_bufid", 64'(buf_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("s5 cnts_zero", 64'({cnt_h, cnt_n}), 64'd0);
    qm_ack = 1'b1;
    observe(1'b1, 9'h55, 1'b1, "s5 regrant");
    check("s5 host_cnt", 64'(cnt_h), 64'(StatOne));
    check("s5 net_cnt", 64'(cnt_n), 64'd0);

    // Ack in IDLE with no requests is ignored
    tick();
    check("s6 idle_wr", 64'(wr_o), 64'd0);
    check("s6 idle_acks", 64'({ack_h, ack_n}), 64'd0);
    check("s6 idle_bufid", 64'(buf_o), 64'h55);
    qm_ack = 1'b0;

    // Ack withheld 50 cycles; network drops its request partway through
    tag_n = 48'hABCD; type_n = 3'd4; buf_n = 9'h77; wr_n = 1'b1;
    tick();
    check("s6 wr", 64'(wr_o), 64'd1);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) wr_n = 1'b0;
      tick();
      check("s6 stall_wr", 64'(wr_o), 64'd1);
      check("s6 stall_desc", 64'({tag_o, type_o, buf_o}), {4'd0, 48'hABCD, 3'd4, 9'h77});
    end
    qm_ack = 1'b1;
    tick();
    check("s6 ack_net", 64'(ack_n), 64'd1);
    check("s6 ack_host", 64'(ack_h), 64'd0);
    qm_ack = 1'b0;
    tick();
    check("s6 ack_net_clear", 64'(ack_n), 64'd0);
    check("s6 net_cnt", 64'(cnt_n), 64'(StatOne));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/output_descriptor_arbiter.md
Name: output_descriptor_arbiter

Overview:
- Per-outport arbiter that merges the two descriptor sources (host port and network port) into a single descriptor stream for the outport's queue/gate scheduler.
- Descriptor = 48-bit TSN tag, 3-bit packet type and 9-bit buffer id.
- Time-sensitive descriptors take strict priority. Ties use round-robin. A starvation guard bounds the wait seen by the losing source.
- Each network_output_process instance uses one arbiter, in front of its queue manager.

Parameters:
TS_TYPE_MAX, 3'd2, pkt_type values 0..TS_TYPE_MAX are time-sensitive (TS); larger values are non-TS.
STARVE_LIMIT, 8, consecutive lost arbitrations (source requesting) before a forced grant; range 1..255; 0 disables the guard.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous reset, active low
iv_tsntag_host  in  48  host descriptor TSN tag
iv_pkt_type_host  in  3  host packet type
iv_bufid_host  in  9  host buffer id
i_descriptor_wr_host  in  1  host request; held with stable data until acked
o_descriptor_ack_host  out  1  one-cycle ack to host
iv_tsntag_network  in  48  network descriptor TSN tag
iv_pkt_type_network  in  3  network packet type
iv_bufid_network  in  9  network buffer id
i_descriptor_wr_network  in  1  network request; held until acked
o_descriptor_ack_network  out  1  one-cycle ack to network
ov_tsntag  out  48  granted TSN tag
ov_pkt_type  out  3  granted packet type
ov_bufid  out  9  granted buffer id
o_descriptor_wr  out  1  descriptor valid to queue manager; held until i_descriptor_ack
i_descriptor_ack  in  1  queue manager accept
ov_host_grant_cnt  out  16  host grants (optional feature)
ov_network_grant_cnt  out  16  network grants (optional feature)

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous, active low.
- Reset values: all outputs 0; state IDLE; rr_last = network (so host wins the first tie); starvation counters 0.
- All outputs are registered.

FSM:
- IDLE: if either request is high, pick a winner, latch its three fields into ov_*, set o_descriptor_wr=1, go to WAIT_ACK. Otherwise stay in IDLE.
- WAIT_ACK: hold ov_* and o_descriptor_wr stable. When i_descriptor_ack=1, at that edge clear o_descriptor_wr, set the winner's o_descriptor_ack_*=1, update rr_last, and go to RELEASE.
- RELEASE: exactly one cycle. Ack is high during this cycle. Both requests are ignored (the source drops wr at this cycle's closing edge). Ack clears at the edge, go to IDLE.

Latency and throughput:
- Request seen in IDLE cycle N gives o_descriptor_wr high in cycle N+1.
- i_descriptor_ack in cycle M gives source ack in M+1 and IDLE in M+2.
- Minimum 3 cycles per descriptor.

Winner selection (evaluated in IDLE), first rule that applies wins:
1. Only one source requesting: that source wins.
2. Exactly one source's starvation counter ≥ STARVE_LIMIT (STARVE_LIMIT≠0): that source wins.
3. Exactly one source has a TS pkt_type: that source wins.
4. Otherwise: round-robin, the source not equal to rr_last wins.

Starvation counters:
- Per source, 8-bit.
- Increment (saturating at 255) when the source requests in IDLE and loses.
- Clear when the source is granted.
- Unchanged when the source is not requesting.

Other rules:
- i_descriptor_ack outside WAIT_ACK is ignored.
- A source's request dropped while in WAIT_ACK does not cancel the issued descriptor.
- Reset asserted mid-transaction: immediately return to reset values. No ack pulse is produced. The pending descriptor is abandoned, and the source must re-request.

Optional Feature:
- Macro: DESC_ARB_STAT_EN.
- Defined: ov_host_grant_cnt and ov_network_grant_cnt each increment by 1 (wrapping 16-bit) on the edge where that source's ack is asserted; reset to 0.
- Undefined: no counter logic; both ports are driven constant 0.

Test Plan:
- Host-only request (tag 48'h1, type 3, bufid 9'h05); ack queue manager 2 cycles after wr rises -> ov_bufid=9'h05 one cycle after request; o_descriptor_ack_host high exactly 1 cycle, the cycle after i_descriptor_ack; network ack stays 0.
- Simultaneous requests: host type 5 (non-TS, bufid 9'h10), network type 1 (TS, bufid 9'h20) -> network granted first (bufid 9'h20), host second.
- Both non-TS, continuously requesting, queue manager acks immediately -> grants alternate host, network, host, network…; first grant is host; one grant every 3 cycles.
- Host always TS, network always non-TS, STARVE_LIMIT=8 -> 8 host grants, then 1 forced network grant, then the pattern repeats; network counter returns to 0 after its grant.
- Reset pulsed in WAIT_ACK -> o_descriptor_wr and both acks go 0 asynchronously. After release, a host-only request is granted normally, with grant counters 0 (macro defined) or constant 0 (macro undefined).
- i_descriptor_ack pulsed while IDLE with no requests -> no output change. Queue manager withholds ack 50 cycles -> ov_* stay stable and o_descriptor_wr stays 1 throughout.
